// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: circular store buffer with byte-granular load forwarding, optional youngest-entry merge (DCACHE_SB_MERGE_EN)
package dcache_pkg;
  localparam int unsigned DCACHE_DATA_WIDTH = 32;
endpackage

package wt_cache_pkg;
  localparam int unsigned DCACHE_NUM_WORDS = 256;
endpackage

module dcache_store_buffer #(
  parameter int unsigned DATA_WIDTH = dcache_pkg::DCACHE_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = wt_cache_pkg::DCACHE_NUM_WORDS,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned ADDR_W    = $clog2(NUM_WORDS),
  localparam int unsigned BW        = DATA_WIDTH / 8,
  localparam int unsigned PW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_W-1:0]     st_addr_i,
  input  logic [BW-1:0]         st_be_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [ADDR_W-1:0]     ld_addr_i,
  output logic [BW-1:0]         ld_fwd_be_o,
  output logic [DATA_WIDTH-1:0] ld_fwd_data_o,
  output logic                  ds_en_o,
  output logic                  ds_we_o,
  output logic [BW-1:0]         ds_write_byte_o,
  output logic [ADDR_W-1:0]     ds_addr_o,
  output logic [DATA_WIDTH-1:0] ds_wdata_o,
  input  logic                  ds_gnt_i,
  output logic                  empty_o
);
  logic [ADDR_W-1:0]     addr_q [DEPTH];
  logic [BW-1:0]         be_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q, tail_q, yng, idx;
  logic [PW:0]           count_q;
  logic                  full, pop, push, accept, addr_hit, merge_hit, do_merge;
  logic [DATA_WIDTH-1:0] merged;

  assign yng     = tail_q - PW'(1);
  assign empty_o = count_q == '0;
  assign full    = count_q == (PW+1)'(DEPTH);
  assign pop     = !empty_o && ds_gnt_i;
`ifdef DCACHE_SB_MERGE_EN
  assign addr_hit  = !empty_o && addr_q[yng] == st_addr_i;
  assign merge_hit = addr_hit && !(count_q == (PW+1)'(1) && pop);
`else
  assign addr_hit  = 1'b0;
  assign merge_hit = 1'b0;
`endif
  // when full the youngest is never the head, so the pop term of a merge hit cannot matter here
  assign st_ready_o = !full || addr_hit;
  assign accept     = st_valid_i && st_ready_o;
  assign push       = accept && |st_be_i && !merge_hit;
  assign do_merge   = accept && merge_hit;

  assign ds_en_o         = !empty_o;
  assign ds_we_o         = !empty_o;
  assign ds_addr_o       = empty_o ? '0 : addr_q[head_q];
  assign ds_write_byte_o = empty_o ? '0 : be_q[head_q];
  assign ds_wdata_o      = empty_o ? '0 : data_q[head_q];

  // overlay incoming bytes onto the youngest entry
  always_comb begin
    merged = '0;
    for (int b = 0; b < BW; b++)
      merged[8*b+:8] = st_be_i[b] ? st_data_i[8*b+:8] : data_q[yng][8*b+:8];
  end

  // walk oldest to youngest so the youngest matching entry wins each byte
  always_comb begin
    ld_fwd_be_o   = '0;
    ld_fwd_data_o = '0;
    idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && addr_q[idx] == ld_addr_i) begin
        ld_fwd_be_o = ld_fwd_be_o | be_q[idx];
        for (int b = 0; b < BW; b++)
          if (be_q[idx][b]) ld_fwd_data_o[8*b+:8] = data_q[idx][8*b+:8];
      end
    end
  end

  // pointers, occupancy and valid bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // entry payload, no reset needed since valid bits gate every use
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= st_addr_i;
      be_q[tail_q]   <= st_be_i;
      data_q[tail_q] <= st_data_i;
    end else if (do_merge) begin
      be_q[yng]   <= be_q[yng] | st_be_i;
      data_q[yng] <= merged;
    end
  end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb_dcache_store_buffer: scoreboard bench for dcache_store_buffer data store writes and forwarding
module tb_dcache_store_buffer;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        st_valid_i = 1'b0, st_ready_o;
  logic [7:0]  st_addr_i = '0, ld_addr_i = '0, ds_addr_o;
  logic [3:0]  st_be_i = '0, ld_fwd_be_o, ds_write_byte_o;
  logic [31:0] st_data_i = '0, ld_fwd_data_o, ds_wdata_o;
  logic        ds_en_o, ds_we_o, ds_gnt_i = 1'b0, empty_o;
  int          n_vec = 0, n_err = 0;
  logic [43:0] sb [$];
  logic [43:0] e;

  dcache_store_buffer #(.DATA_WIDTH(32), .NUM_WORDS(256), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_be_i(st_be_i), .st_data_i(st_data_i), .ld_addr_i(ld_addr_i),
    .ld_fwd_be_o(ld_fwd_be_o), .ld_fwd_data_o(ld_fwd_data_o), .ds_en_o(ds_en_o), .ds_we_o(ds_we_o),
    .ds_write_byte_o(ds_write_byte_o), .ds_addr_o(ds_addr_o), .ds_wdata_o(ds_wdata_o),
    .ds_gnt_i(ds_gnt_i), .empty_o(empty_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every granted data store write must match the oldest expected write
  always @(negedge clk_i)
    if (rst_ni && ds_en_o && ds_gnt_i) begin
      if (sb.size() == 0) chk("sb_extra_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ds_addr", ds_addr_o, e[43:36]);
        chk("ds_be", ds_write_byte_o, e[35:32]);
        chk("ds_wdata", ds_wdata_o, e[31:0]);
        chk("ds_we", ds_we_o, 1);
      end
    end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
    int k;
    st_valid_i = 1'b1; st_addr_i = a; st_be_i = b; st_data_i = d;
    #1;
    for (k = 0; k < 50 && !st_ready_o; k++) step();
    if (k == 50) chk("store_timeout", 0, 1);
    step();
    st_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    ds_gnt_i = 1'b1;
    for (k = 0; k < 20 && !empty_o; k++) step();
    if (k == 20) chk("drain_timeout", 0, 1);
    ds_gnt_i = 1'b0;
  endtask

  initial begin
    ld_addr_i = 8'h10;
    step();
    step();
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", st_ready_o, 1);
    chk("rst_ds", {ds_en_o, ds_we_o, ds_write_byte_o, ds_addr_o, ds_wdata_o}, 0);
    chk("rst_fwd_be", ld_fwd_be_o, 0);
    rst_ni = 1'b1;
    step();

    store(8'h10, 4'hF, 32'hDEADBEEF);
    sb.push_back({8'h10, 4'hF, 32'hDEADBEEF});
    chk("one_empty", empty_o, 0);
    chk("one_ds_en", ds_en_o, 1);
    chk("one_addr", ds_addr_o, 8'h10);
    chk("one_wdata", ds_wdata_o, 32'hDEADBEEF);
    chk("one_fwd", {ld_fwd_be_o, ld_fwd_data_o}, {4'hF, 32'hDEADBEEF});
    ds_gnt_i = 1'b1;
    step();
    ds_gnt_i = 1'b0;
    chk("one_drained", empty_o, 1);

    for (int i = 0; i < 4; i++) begin
      store(8'h20 + 8'(i), 4'hF, 32'h100 + i);
      sb.push_back({8'h20 + 8'(i), 4'hF, 32'h100 + i});
    end
    chk("full_ready", st_ready_o, 0);
    ld_addr_i = 8'h22;
    #1;
    chk("full_fwd", {ld_fwd_be_o, ld_fwd_data_o}, {4'hF, 32'h102});
    st_valid_i = 1'b1; st_addr_i = 8'h30; st_be_i = 4'hF; st_data_i = 32'h555;
    step();
    chk("stall_ready", st_ready_o, 0);
    chk("stall_head", ds_addr_o, 8'h20);
    ds_gnt_i = 1'b1;
    step();
    ds_gnt_i = 1'b0;
    chk("after_gnt_ready", st_ready_o, 1);
    step();
    st_valid_i = 1'b0;
    sb.push_back({8'h30, 4'hF, 32'h555});
    drain();

    store(8'h08, 4'h3, 32'h0000AAAA);
    store(8'h08, 4'hC, 32'hBBBB0000);
`ifdef DCACHE_SB_MERGE_EN
    sb.push_back({8'h08, 4'hF, 32'hBBBBAAAA});
`else
    sb.push_back({8'h08, 4'h3, 32'h0000AAAA});
    sb.push_back({8'h08, 4'hC, 32'hBBBB0000});
`endif
    ld_addr_i = 8'h08;
    #1;
    chk("merge_fwd", {ld_fwd_be_o, ld_fwd_data_o}, {4'hF, 32'hBBBBAAAA});
    drain();

    store(8'h40, 4'h0, 32'h12345678);
    chk("zero_be_empty", empty_o, 1);

    store(8'h04, 4'h1, 32'h11);
    store(8'h04, 4'h3, 32'h2222);
`ifdef DCACHE_SB_MERGE_EN
    sb.push_back({8'h04, 4'h3, 32'h2222});
`else
    sb.push_back({8'h04, 4'h1, 32'h11});
    sb.push_back({8'h04, 4'h3, 32'h2222});
`endif
    ld_addr_i = 8'h04;
    #1;
    chk("fwd_be", ld_fwd_be_o, 4'h3);
    chk("fwd_data", ld_fwd_data_o, 32'h00002222);
    ld_addr_i = 8'h05;
    #1;
    chk("fwd_miss", {ld_fwd_be_o, ld_fwd_data_o}, 0);
    drain();

    for (int i = 0; i < 3; i++) store(8'h50 + 8'(i), 4'hF, 32'hA0 + i);
    chk("pre_rst_empty", empty_o, 0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_ds_en", ds_en_o, 0);
    chk("mid_rst_ready", st_ready_o, 1);
    step();
    rst_ni = 1'b1;
    ds_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ds_gnt_i = 1'b0;
    chk("post_rst_empty", empty_o, 1);
    chk("post_rst_ds_en", ds_en_o, 0);
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
